// File: rtl/usb_tx_sched.sv
// Shares the usb_tx path between handshake and DATA requesters; grant and tx_packet follow a request by one clock,
// requests are held until granted, and an idle gap follows every packet. Optional tx_done watchdog: USB_TX_TIMEOUT_EN.
module usb_tx_sched #(
   parameter int GAP_CYCLES     = 16,
   parameter int STARVE_LIMIT   = 4,
   parameter int MAX_DATA_SIZE  = 64,
   parameter int TIMEOUT_CYCLES = 8192
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hs_req,
   input  logic       hs_nak,
   input  logic       data_req,
   input  logic [6:0] data_size,
   input  logic       tx_done,
   output logic [1:0] tx_packet,
   output logic [6:0] tx_packet_data_size,
   output logic       hs_grant,
   output logic       data_grant,
   output logic       size_err,
   output logic       tx_complete,
   output logic       complete_data,
   output logic       busy,
   output logic       tx_abort
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   localparam logic [1:0] PKT_IDLE = 2'b00;
   localparam logic [1:0] PKT_DATA = 2'b01;
   localparam logic [1:0] PKT_ACK  = 2'b10;
   localparam logic [1:0] PKT_NAK  = 2'b11;

   localparam logic [6:0] MAX_SIZE   = 7'(MAX_DATA_SIZE);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

   state_t     state;
   logic [7:0] gap_cnt;
   logic [3:0] starve_cnt;
   logic       pick_data;
   logic       size_over;
   logic       to_hit;

   // Data wins when handshake is absent or has starved it STARVE_LIMIT times in a row.
   assign pick_data = data_req && (!hs_req || starve_cnt == STARVE_MAX);
   assign size_over = data_size > MAX_SIZE;

`ifdef USB_TX_TIMEOUT_EN
   localparam int            TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt;
   assign to_hit = (to_cnt == TO_LAST);
`else
   // Watchdog compiled out: false for every legal limit.
   assign to_hit = (TIMEOUT_CYCLES < 1);
`endif

   always_ff @(posedge clk) begin
      hs_grant      <= 1'b0;
      data_grant    <= 1'b0;
      size_err      <= 1'b0;
      tx_complete   <= 1'b0;
      complete_data <= 1'b0;
      tx_abort      <= 1'b0;
      if (rst) begin
         state               <= S_IDLE;
         tx_packet           <= PKT_IDLE;
         tx_packet_data_size <= 7'd0;
         busy                <= 1'b0;
         gap_cnt             <= 8'd0;
         starve_cnt          <= 4'd0;
`ifdef USB_TX_TIMEOUT_EN
         to_cnt              <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_data) begin
                  data_grant          <= 1'b1;
                  size_err            <= size_over;
                  tx_packet           <= PKT_DATA;
                  tx_packet_data_size <= size_over ? MAX_SIZE : data_size;
                  busy                <= 1'b1;
                  state               <= S_SEND;
               end else if (hs_req) begin
                  hs_grant            <= 1'b1;
                  tx_packet           <= hs_nak ? PKT_NAK : PKT_ACK;
                  tx_packet_data_size <= 7'd0;
                  busy                <= 1'b1;
                  state               <= S_SEND;
               end
`ifdef USB_TX_TIMEOUT_EN
               to_cnt <= '0;
`endif
            end
            S_SEND: begin
               if (tx_done) begin
                  tx_complete         <= 1'b1;
                  complete_data       <= (tx_packet == PKT_DATA);
                  tx_packet           <= PKT_IDLE;
                  tx_packet_data_size <= 7'd0;
                  gap_cnt             <= 8'd0;
                  state               <= S_GAP;
               end else if (to_hit) begin
                  tx_abort            <= 1'b1;
                  tx_packet           <= PKT_IDLE;
                  tx_packet_data_size <= 7'd0;
                  gap_cnt             <= 8'd0;
                  state               <= S_GAP;
               end
`ifdef USB_TX_TIMEOUT_EN
               else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end
            default: begin
               state     <= S_IDLE;
               tx_packet <= PKT_IDLE;
               busy      <= 1'b0;
            end
         endcase

         // Only handshake wins taken over a waiting data request count toward starvation.
         if (!data_req)
            starve_cnt <= 4'd0;
         else if (state == S_IDLE && pick_data)
            starve_cnt <= 4'd0;
         else if (state == S_IDLE && hs_req)
            starve_cnt <= starve_cnt + 4'd1;
      end
   end

endmodule

// File: tb/tb_usb_tx_sched.sv
// Directed bench for usb_tx_sched: a timestamp-based reference model is compared on every cycle, plus literal checks.
module tb_usb_tx_sched;

   localparam int GAP   = 16;
   localparam int LIMIT = 4;
   localparam int MAXSZ = 64;
   localparam int TO    = 32;
`ifdef USB_TX_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       hs_req, hs_nak, data_req, tx_done;
   logic [6:0] data_size;
   logic [1:0] tx_packet;
   logic [6:0] tx_packet_data_size;
   logic       hs_grant, data_grant, size_err, tx_complete, complete_data, busy, tx_abort;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   usb_tx_sched #(
      .GAP_CYCLES(GAP), .STARVE_LIMIT(LIMIT), .MAX_DATA_SIZE(MAXSZ), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .hs_req(hs_req), .hs_nak(hs_nak), .data_req(data_req),
      .data_size(data_size), .tx_done(tx_done), .tx_packet(tx_packet),
      .tx_packet_data_size(tx_packet_data_size), .hs_grant(hs_grant), .data_grant(data_grant),
      .size_err(size_err), .tx_complete(tx_complete), .complete_data(complete_data),
      .busy(busy), .tx_abort(tx_abort)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: edge k counts clock edges; the scheduler is free to grant from edge idle_from on.
   int         k = 0;
   bit         m_send = 1'b0, m_data = 1'b0, g_h, g_d;
   int         m_idle_from = 0, m_grant_at = 0, m_starve = 0;
   logic [1:0] e_pkt = 2'b00;
   logic [6:0] e_size = 7'd0;
   bit         e_hsg, e_dg, e_serr, e_cmp, e_cd, e_busy, e_abort;

   initial begin
      forever begin
         @(posedge clk);
         k++;
         e_hsg = 0; e_dg = 0; e_serr = 0; e_cmp = 0; e_cd = 0; e_abort = 0;
         g_h = 0; g_d = 0;
         if (rst) begin
            m_send = 0; e_pkt = 2'b00; e_size = 7'd0; m_idle_from = k + 1; m_starve = 0;
         end else begin
            if (m_send) begin
               if (tx_done) begin
                  e_cmp = 1; e_cd = m_data; e_pkt = 2'b00; e_size = 7'd0;
                  m_send = 0; m_idle_from = k + GAP + 1;
               end else if (TO_EN && (k - m_grant_at == TO)) begin
                  e_abort = 1; e_pkt = 2'b00; e_size = 7'd0;
                  m_send = 0; m_idle_from = k + GAP + 1;
               end
            end else if (k >= m_idle_from) begin
               if (data_req && (!hs_req || m_starve == LIMIT)) g_d = 1;
               else if (hs_req) g_h = 1;
               if (g_d) begin
                  e_dg = 1; m_send = 1; m_data = 1; m_grant_at = k; e_pkt = 2'b01;
                  e_serr = (data_size > MAXSZ);
                  e_size = e_serr ? 7'(MAXSZ) : data_size;
               end
               if (g_h) begin
                  e_hsg = 1; m_send = 1; m_data = 0; m_grant_at = k;
                  e_pkt = hs_nak ? 2'b11 : 2'b10; e_size = 7'd0;
               end
            end
            if (!data_req || g_d) m_starve = 0;
            else if (g_h) m_starve = m_starve + 1;
         end
         e_busy = m_send || (k < m_idle_from - 1);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("m_tx_packet", tx_packet, e_pkt);
            check("m_size", tx_packet_data_size, e_size);
            check("m_hs_grant", hs_grant, e_hsg);
            check("m_data_grant", data_grant, e_dg);
            check("m_size_err", size_err, e_serr);
            check("m_tx_complete", tx_complete, e_cmp);
            check("m_complete_data", complete_data, e_cd);
            check("m_busy", busy, e_busy);
            check("m_tx_abort", tx_abort, e_abort);
         end
      end
   end

   task automatic pulse_done();
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   task automatic wait_grant(output bit is_data);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(hs_grant || data_grant) && n < 100);
      check("grant_seen", 32'(n < 100), 1);
      is_data = data_grant;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int         b, n;
      bit         d;
      logic [9:0] order;

      rst = 1; hs_req = 0; hs_nak = 0; data_req = 0; data_size = 0; tx_done = 0;
      repeat (2) @(negedge clk);
      chk_en = 1;
      check("rst_tx_packet", tx_packet, 2'b00);
      check("rst_busy", busy, 0);
      check("rst_size", tx_packet_data_size, 0);
      rst = 0;
      @(negedge clk);

      // Single ACK with gap length
      hs_req = 1; hs_nak = 0;
      @(negedge clk);
      check("ack_grant", hs_grant, 1);
      check("ack_pkt", tx_packet, 2'b10);
      hs_req = 0;
      repeat (3) @(negedge clk);
      check("ack_hold", tx_packet, 2'b10);
      pulse_done();
      check("ack_done_pkt", tx_packet, 2'b00);
      check("ack_complete", tx_complete, 1);
      check("ack_cdata", complete_data, 0);
      b = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) b++;
      end
      check("busy_len", b + 1, 16);

      // Simultaneous requests: ACK first, DATA after the gap
      hs_req = 1; data_req = 1; data_size = 7'd1;
      @(negedge clk);
      check("both_hs_first", hs_grant, 1);
      check("both_no_data", data_grant, 0);
      hs_req = 0;
      @(negedge clk);
      pulse_done();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!data_grant && n < 40);
      check("data_after_gap", n, 17);
      check("data_pkt", tx_packet, 2'b01);
      check("data_size1", tx_packet_data_size, 1);
      data_req = 0;
      @(negedge clk);
      pulse_done();
      check("data_cdata", complete_data, 1);
      repeat (GAP + 1) @(negedge clk);

      // Starvation: two rounds of four handshakes then one data
      hs_req = 1; data_req = 1; data_size = 7'd5;
      order = '0;
      for (int i = 0; i < 10; i++) begin
         wait_grant(d);
         order = {order[8:0], d};
         if (i == 9) begin
            data_req = 0; hs_req = 0;
         end
         pulse_done();
      end
      check("starve_order", order, 10'b0000100001);
      repeat (GAP + 2) @(negedge clk);

      // Size clamp and zero-length
      data_req = 1; data_size = 7'd100;
      @(negedge clk);
      check("big_grant", data_grant, 1);
      check("big_err", size_err, 1);
      check("big_size", tx_packet_data_size, 64);
      data_req = 0;
      pulse_done();
      repeat (GAP + 1) @(negedge clk);
      data_req = 1; data_size = 7'd0;
      @(negedge clk);
      check("zero_grant", data_grant, 1);
      check("zero_err", size_err, 0);
      check("zero_size", tx_packet_data_size, 0);
      check("zero_pkt", tx_packet, 2'b01);
      data_req = 0;
      pulse_done();
      repeat (GAP + 1) @(negedge clk);

      // Reset during a NAK
      hs_req = 1; hs_nak = 1;
      @(negedge clk);
      check("nak_pkt", tx_packet, 2'b11);
      hs_req = 0;
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk);
      check("rstsend_pkt", tx_packet, 2'b00);
      check("rstsend_busy", busy, 0);
      check("rstsend_cmp", tx_complete, 0);
      rst = 0; hs_nak = 0; hs_req = 1;
      @(negedge clk);
      check("after_rst_grant", hs_grant, 1);
      check("after_rst_pkt", tx_packet, 2'b10);
      hs_req = 0;
      pulse_done();
      repeat (GAP + 1) @(negedge clk);

      // Withheld tx_done
      data_req = 1; data_size = 7'd8;
      @(negedge clk);
      check("to_grant", data_grant, 1);
      data_req = 0;
`ifdef USB_TX_TIMEOUT_EN
      repeat (TO - 1) @(negedge clk);
      check("to_pre_pkt", tx_packet, 2'b01);
      check("to_pre_abort", tx_abort, 0);
      @(negedge clk);
      check("to_abort", tx_abort, 1);
      check("to_pkt", tx_packet, 2'b00);
      check("to_cmp", tx_complete, 0);
      check("to_busy", busy, 1);
`else
      repeat (120) @(negedge clk);
      check("noto_pkt", tx_packet, 2'b01);
      check("noto_abort", tx_abort, 0);
      pulse_done();
      check("noto_cmp", tx_complete, 1);
`endif
      repeat (GAP + 1) @(negedge clk);

      // Stray tx_done in IDLE, and a request dropped during GAP
      pulse_done();
      check("stray_done", tx_complete, 0);
      hs_req = 1;
      @(negedge clk);
      hs_req = 0;
      pulse_done();
      data_req = 1; data_size = 7'd3;
      repeat (5) @(negedge clk);
      data_req = 0;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (hs_grant || data_grant) n++;
      end
      check("dropped_req", n, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/usb_tx_sched.md
Name: usb_tx_sched

Overview:
Scheduler in front of usb_tx that shares the single USB transmit path between two requesters. The RX/protocol side asks for handshake packets (ACK/NAK); the AHB-slave side asks for DATA packets of a given byte count. The block arbitrates, drives tx_packet/tx_packet_data_size, holds them until usb_tx reports tx_done, then enforces an inter-packet gap before the next grant.

Parameters:
GAP_CYCLES, 16, idle clocks enforced after each tx_done before the next grant (2 bit times at 8 clk/bit); legal 1..255.
STARVE_LIMIT, 4, consecutive handshake grants allowed while data_req is pending before data gets forced priority; legal 1..15.
MAX_DATA_SIZE, 64, largest legal DATA payload in bytes.
TIMEOUT_CYCLES, 8192, tx_done watchdog limit; used only with the optional feature.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
hs_req  in  1  level; handshake wanted, held until hs_grant
hs_nak  in  1  handshake type sampled with hs_req: 0=ACK, 1=NAK
data_req  in  1  level; DATA packet wanted, held until data_grant
data_size  in  7  payload bytes sampled with data_req
tx_done  in  1  one-cycle pulse from usb_tx, packet finished
tx_packet  out  2  to usb_tx: 00 IDLE, 01 DATA, 10 ACK, 11 NAK
tx_packet_data_size  out  7  to usb_tx; valid while tx_packet==01
hs_grant  out  1  one-cycle pulse, handshake accepted
data_grant  out  1  one-cycle pulse, data request accepted
size_err  out  1  one-cycle pulse with data_grant when data_size > MAX_DATA_SIZE
tx_complete  out  1  one-cycle pulse, a scheduled packet finished
complete_data  out  1  valid with tx_complete: 1 = finished packet was DATA
busy  out  1  high in SEND and GAP
tx_abort  out  1  one-cycle pulse on watchdog abort; tied 0 without the feature

Behaviour:
- All outputs are registered. On reset: tx_packet=00, size=0, all pulses 0, busy=0, starve counter 0, state IDLE.
- States:
  - IDLE: on any request, grant at the next edge and enter SEND. tx_packet, grant and size become valid in the cycle after the request is first seen (1-cycle latency).
  - SEND: tx_packet and size are held constant. On the edge that samples tx_done=1, tx_packet goes to 00, tx_complete pulses with complete_data set, and the state moves to GAP.
  - GAP: count GAP_CYCLES clocks, then return to IDLE. No grant is issued in GAP; requests stay pending.
- Arbitration in IDLE:
  - hs_req beats data_req, unless starve_cnt==STARVE_LIMIT and data_req=1.
  - starve_cnt increments on each hs grant made while data_req=1, and clears on any data grant or whenever data_req=0.
- Size handling:
  - Sizes above MAX_DATA_SIZE are clamped to MAX_DATA_SIZE and size_err pulses.
  - Size 0 is legal (zero-length DATA packet).
- tx_done seen outside SEND is ignored.
- Reset mid-SEND or mid-GAP returns tx_packet to 00 immediately at that edge. The pending packet is lost; requesters re-present.
- A request dropped before its grant is not served and leaves no residue.

Optional Feature:
USB_TX_TIMEOUT_EN:
- Defined: a counter runs in SEND. If it reaches TIMEOUT_CYCLES without tx_done, then at that edge tx_packet goes to 00, tx_abort pulses, tx_complete stays 0, and the state moves to GAP.
- Undefined: no counter; SEND waits for tx_done indefinitely; tx_abort is constant 0.

Test Plan:
- Reset, then hs_req=1, hs_nak=0 at cycle N → cycle N+1: tx_packet=10, hs_grant=1. tx_packet holds until tx_done. tx_done pulse → next cycle tx_packet=00, tx_complete=1, complete_data=0; busy high for 16 more cycles.
- hs_req and data_req (size 1) both asserted at cycle N → ACK granted first. The DATA grant (tx_packet=01, size=1) occurs exactly 16 cycles after the ACK's tx_done edge returns the block to IDLE, plus 1 cycle.
- hs_req held continuously with data_req=1, STARVE_LIMIT=4 → grant order is H, H, H, H, D, H; starve_cnt returns to 0 after D.
- data_req with data_size=100 → data_grant=1, size_err=1, tx_packet_data_size=64. With data_size=0 → size=0 and no size_err.
- Assert rst during SEND of a NAK → next cycle tx_packet=00, busy=0, no tx_complete. A later hs_req is granted normally.
- With USB_TX_TIMEOUT_EN and TIMEOUT_CYCLES=32, grant DATA and withhold tx_done → after 32 SEND cycles tx_abort=1, tx_packet=00, tx_complete=0, then GAP. Without the macro the same stimulus keeps tx_packet=01 beyond 100 cycles and tx_abort stays 0.
